button_debounce: RTL and testbench
==================================

# button_debounce

Debounces and synchronises WIDTH raw push-button or switch inputs and drives clean, glitch-free levels into the 5-bit `in_port` of the Nios PIO. It sits directly upstream of that PIO, so each PIO edge-capture bit and IRQ fires once per physical press, not once per contact bounce. It also produces registered one-cycle press and release pulses for local hardware consumers.

## Interface
- `WIDTH`, default 5: number of independent input channels; must match the PIO `in_port` width.
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required before a change is accepted. This is 1 ms at 50 MHz. Legal range 2..2^24.
- `clk`  input  1: system clock, the same clock as the PIO.
- `reset`  input  1: asynchronous, active-high reset.
- `btn_raw`  input  WIDTH: asynchronous raw pad inputs.
- `btn_clean`  output  WIDTH: debounced level, connects to the PIO `in_port`.
- `rise_pulse`  output  WIDTH: per-bit one-cycle pulse when `btn_clean` goes 0->1.
- `fall_pulse`  output  WIDTH: per-bit one-cycle pulse when `btn_clean` goes 1->0.

## Operation
- Input conditioning, per bit:
  - `in_n` is `btn_raw` passed through the optional inversion (see Configuration).
  - `in_n` then goes through a 2-FF synchroniser, `sync1` -> `sync2`.
- Per-bit state: a `stable` register and a counter `cnt`. The counter width is $clog2(DEBOUNCE_CYCLES). Channels are fully independent.
- Each clock edge, per bit:
  - If `sync2 == stable`: `cnt <= 0`.
  - Else, if `cnt == DEBOUNCE_CYCLES-1`: `stable <= sync2`, `cnt <= 0`, and the bit's update flag is set for this edge.
  - Else: `cnt <= cnt + 1`.
- Any single cycle where `sync2` returns to `stable` clears `cnt`. The full DEBOUNCE_CYCLES run must then restart, so bounces shorter than the window never propagate.
- `btn_clean = stable`, driven directly from the register with no combinational path from `btn_raw`.
- Pulses are registered at the same edge as the `stable` update:
  - `rise_pulse[i] <= update[i] & sync2[i]`
  - `fall_pulse[i] <= update[i] & ~sync2[i]`
  - Otherwise both are 0.
- The counter never wraps. It saturates logically at DEBOUNCE_CYCLES-1, where it either commits the change or is cleared.
- Simultaneous changes on several bits are handled in parallel, and pulses may assert on several bits in the same cycle.

## Timing
- Reset values, asserted asynchronously and held while `reset`=1:
  - `sync1`, `sync2`, `stable`, `cnt` all 0.
  - `btn_clean`, `rise_pulse`, `fall_pulse` all 0.
- Reset mid-count discards the partial count. After release, a held-active input needs the full DEBOUNCE_CYCLES+2 cycles before `btn_clean` follows.
- Latency: `btn_raw` changes and is then held.
  - Edge k samples it into `sync1`; edge k+1 puts it in `sync2`.
  - Edges k+2..k+1+DEBOUNCE_CYCLES count the mismatch.
  - `btn_clean` and the pulse update at edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 edges counting edge k as the first.
- Each pulse is exactly one cycle wide and coincident with the first cycle of the new `btn_clean` value.
- Minimum accepted stable width is DEBOUNCE_CYCLES cycles as seen at `sync2`. A toggle that is stable for only DEBOUNCE_CYCLES-1 cycles is rejected.
- Downstream PIO edge detection adds its own two register stages. That is outside this block.

## Configuration
- Macro `BUTTON_DEBOUNCE_INVERT_EN`.
- Defined: `in_n = ~btn_raw`. This is for active-low board KEYs. A pressed key reads 1 on `btn_clean` and produces `rise_pulse` on press.
- Not defined: `in_n = btn_raw`, with no inversion.
- Reset values are identical in both builds, all 0.
  - With the macro defined and keys released (raw 1), `in_n` = 0 matches `stable` = 0.
  - So no spurious pulse occurs after reset.

## Test plan
All scenarios use `WIDTH`=5, `DEBOUNCE_CYCLES`=4, macro undefined unless stated.

- **Reset:** assert `reset` with `btn_raw`=5'h1F. All outputs read 0 during reset. After release, `btn_clean`=5'h1F exactly 6 edges later, with `rise_pulse`=5'h1F for that single cycle.
- **Clean press:** `btn_raw[0]` goes 0->1 and is held. `btn_clean[0]` rises 6 edges after first sampling, `rise_pulse[0]` is high for exactly 1 cycle, and the other bits are unchanged.
- **Bounce rejection:** `btn_raw[2]` toggles 1,0,1,0 with 3-cycle high phases. `btn_clean[2]` stays 0 and no pulse occurs. It is then held high, and `btn_clean[2]` rises 6 edges after the final rise.
- **Simultaneous channels:** bits 1 and 4 rise on the same cycle while bit 3 falls from a stable 1. Result: `btn_clean` updates on all three in the same cycle, `rise_pulse`=5'h12 and `fall_pulse`=5'h08 for one cycle.
- **Reset mid-count:** hold `btn_raw[0]`=1 for 3 cycles, then assert `reset` for 1 cycle. `cnt` clears, and after release `btn_clean[0]` rises only after a full 6 edges.
- **Inversion build:** define `BUTTON_DEBOUNCE_INVERT_EN` with `btn_raw`=5'h1F idle. There is no pulse after reset. Driving `btn_raw[1]`=0 gives `btn_clean[1]`=1 and `rise_pulse[1]` after 6 edges.

Source files
------------

// File: rtl/button_debounce.sv
// Per-channel synchroniser and debouncer feeding a PIO in_port, with one-cycle press/release pulses.
// Optional build macro BUTTON_DEBOUNCE_INVERT_EN inverts the raw inputs (active-low keys).
module button_debounce #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_clean,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] in_n;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] update_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

`ifdef BUTTON_DEBOUNCE_INVERT_EN
  assign in_n = ~btn_raw;
`else
  assign in_n = btn_raw;
`endif

  // A single cycle of agreement with the stable level restarts the whole window.
  always_comb begin
    stable_d = stable_q;
    update_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
        update_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    rise_d = update_d & sync2_q;
    fall_d = update_d & ~sync2_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= in_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btn_clean  = stable_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce (WIDTH=5, DEBOUNCE_CYCLES=4); stimulus uses logical
// levels so the same vectors apply with or without BUTTON_DEBOUNCE_INVERT_EN.
module tb_button_debounce;

  localparam int W  = 5;
  localparam int DC = 4;
  localparam int LAT = DC + 2;
  localparam int EW = 32 + 3 * W;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] btn_raw;
  logic [W-1:0] btn_clean, rise_pulse, fall_pulse;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [W-1:0]  exp_clean = '0;
  logic [EW-1:0] exp_q[$];

  button_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .btn_clean(btn_clean), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  // driver tasks
  function automatic logic [W-1:0] raw_of(input logic [W-1:0] v);
`ifdef BUTTON_DEBOUNCE_INVERT_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] v);
    btn_raw = raw_of(v);
  endtask

  task automatic expect_ev(input logic [W-1:0] c, input logic [W-1:0] r, input logic [W-1:0] f);
    exp_q.push_back({32'(cyc + LAT), c, r, f});
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    checks++;
    if (btn_clean !== '0 || rise_pulse !== '0 || fall_pulse !== '0) begin
      errors++;
      $display("FAIL %s clean=%h rise=%h fall=%h expected all 0", tag, btn_clean, rise_pulse, fall_pulse);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] it;
    if (reset) begin
      exp_clean = '0;
    end else begin
      if (exp_q.size() > 0 && int'(exp_q[0][EW-1:3*W]) < cyc) begin
        it = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_event at cyc %0d: nothing seen, expected clean=%h rise=%h fall=%h",
                 int'(it[EW-1:3*W]), it[3*W-1:2*W], it[2*W-1:W], it[W-1:0]);
        exp_clean = it[3*W-1:2*W];
      end
      if ((rise_pulse | fall_pulse) != '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d clean=%h rise=%h fall=%h expected no event",
                   cyc, btn_clean, rise_pulse, fall_pulse);
        end else begin
          it = exp_q.pop_front();
          if (int'(it[EW-1:3*W]) != cyc || btn_clean !== it[3*W-1:2*W] ||
              rise_pulse !== it[2*W-1:W] || fall_pulse !== it[W-1:0]) begin
            errors++;
            $display("FAIL event cyc=%0d clean=%h rise=%h fall=%h expected cyc=%0d clean=%h rise=%h fall=%h",
                     cyc, btn_clean, rise_pulse, fall_pulse, int'(it[EW-1:3*W]),
                     it[3*W-1:2*W], it[2*W-1:W], it[W-1:0]);
          end
          exp_clean = it[3*W-1:2*W];
        end
      end else begin
        checks++;
        if (btn_clean !== exp_clean) begin
          errors++;
          $display("FAIL clean_level cyc=%0d clean=%h expected %h", cyc, btn_clean, exp_clean);
        end
      end
    end
  end

  initial begin
    // reset with all buttons active
    reset = 1'b1;
    drive(5'h1F);
    check_reset_outputs("reset_hold_a");
    check_reset_outputs("reset_hold_b");
    step(1);
    reset = 1'b0;
    expect_ev(5'h1F, 5'h1F, 5'h00);
    step(10);

    // release everything
    drive(5'h00);
    expect_ev(5'h00, 5'h00, 5'h1F);
    step(10);

    // clean press on bit 0
    drive(5'h01);
    expect_ev(5'h01, 5'h01, 5'h00);
    step(10);

    // bounce on bit 2: high phases one cycle short of the window
    for (int i = 0; i < 2; i++) begin
      drive(5'h05);
      step(3);
      drive(5'h01);
      step(3);
    end
    drive(5'h05);
    expect_ev(5'h05, 5'h04, 5'h00);
    step(10);

    // set bit 3, then bits 1 and 4 rise while bit 3 falls
    drive(5'h0D);
    expect_ev(5'h0D, 5'h08, 5'h00);
    step(10);
    drive(5'h17);
    expect_ev(5'h17, 5'h12, 5'h08);
    step(10);

    drive(5'h00);
    expect_ev(5'h00, 5'h00, 5'h17);
    step(10);

    // reset mid-count discards the partial window
    drive(5'h01);
    step(3);
    reset = 1'b1;
    check_reset_outputs("reset_midcount");
    step(1);
    reset = 1'b0;
    expect_ev(5'h01, 5'h01, 5'h00);
    step(10);

    // reset with idle inputs must not produce any pulse afterwards
    drive(5'h00);
    reset = 1'b1;
    check_reset_outputs("reset_idle");
    step(1);
    reset = 1'b0;
    step(12);

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) step(1);
    while (exp_q.size() > 0) begin
      logic [EW-1:0] it;
      it = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL drain leftover event expected at cyc %0d clean=%h", int'(it[EW-1:3*W]), it[3*W-1:2*W]);
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
